tb_run_ctrl: RTL
================

TB_RUN_CTRL -- requirements
Module: tb_run_ctrl

Interface
REQ-001 Parameter RESET_WAIT_CYCLES, default 4: core reset hold length in clk_i cycles after rst_ni deasserts (legal 1..255).
REQ-002 Parameter BASE_ADDR, default 32'h2000_0000: register window base; 16-byte aligned.
REQ-003 Parameter PASS_CODE, default 32'd123456789: STATUS write value meaning pass.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 req_i  in  1  data-bus request.
REQ-007 we_i  in  1  write enable.
REQ-008 be_i  in  4  byte enables.
REQ-009 addr_i  in  32  byte address.
REQ-010 wdata_i  in  32  write data.
REQ-011 gnt_o  out  1  request grant.
REQ-012 rvalid_o  out  1  response valid.
REQ-013 rdata_o  out  32  read data.
REQ-014 core_rst_no  out  1  active-low core reset, registered.
REQ-015 fetch_enable_o  out  1  core fetch enable, registered.
REQ-016 tests_passed_o / tests_failed_o / exit_valid_o / timeout_o  out  1 each  sticky completion flags.
REQ-017 exit_value_o  out  32  exit code.

Function
REQ-018 FSM states: HOLD, RUN, DONE; a 2-bit encoding shall be used.
REQ-019 HOLD: hold counter increments each cycle; at count RESET_WAIT_CYCLES-1, next state is RUN.
REQ-020 core_rst_no = 1 and fetch_enable_o = 1 only in RUN; both shall be 0 in HOLD and DONE.
REQ-021 gnt_o = req_i combinationally in RUN and DONE; gnt_o = 0 in HOLD.
REQ-022 Each granted request in cycle N shall produce rvalid_o = 1 in cycle N+1 only, for reads and writes alike.
REQ-023 Hit: addr_i[31:4] == BASE_ADDR[31:4]; register offset is addr_i[3:2]; addr_i[1:0] is ignored.
REQ-024 Offset 0 STATUS (WO): full-word write in RUN of PASS_CODE sets tests_passed_o; a write of 1 sets tests_failed_o; other values are ignored.
REQ-025 Offset 1 EXIT (WO): full-word write in RUN sets exit_value_o = wdata_i and exit_valid_o = 1.
REQ-026 Offset 2 CYCLE (RO): 32-bit count of RUN cycles.
REQ-027 Offset 3 MAXCYC (RW): timeout limit; 0 disables timeout.
REQ-028 Full-word means be_i == 4'b1111; any write with other be_i shall be granted with no effect.
REQ-029 Reads of WO registers, misses, and unmapped offsets shall return 0; writes to RO registers and misses shall have no effect.
REQ-030 rdata_o shall be valid with rvalid_o and shall be 0 whenever rvalid_o = 0.
REQ-031 CYCLE increments by 1 each RUN cycle and saturates at 32'hFFFF_FFFF; it is frozen in HOLD and DONE.
REQ-032 Timeout: in RUN with MAXCYC != 0 and CYCLE >= MAXCYC, set timeout_o and enter DONE next cycle.
REQ-033 Any flag set in REQ-024/025/032 shall transition RUN->DONE on the same edge; flags become visible one cycle after the accepting edge.
REQ-034 Simultaneous software completion write and timeout condition: the software flag is set, timeout_o stays 0.
REQ-035 In DONE, the bus remains serviced (reads and MAXCYC writes); STATUS/EXIT writes shall be ignored and flags shall not change.
REQ-036 DONE is exited only by reset.

Reset
REQ-037 While rst_ni = 0 at a clock edge: state = HOLD, hold counter = 0, CYCLE = 0, MAXCYC = 0.
REQ-038 Reset values: all flags = 0, exit_value_o = 0, rvalid_o = 0, core_rst_no = 0, fetch_enable_o = 0.
REQ-039 Reset asserted mid-RUN or in DONE shall abort any pending rvalid_o and restart the full HOLD sequence.

Verification
REQ-040 Release rst_ni with RESET_WAIT_CYCLES=4 -> core_rst_no and fetch_enable_o rise exactly 4 edges later; req_i held high sees gnt_o = 0 until then.
REQ-041 Write 123456789 to BASE+0 with be 4'hF -> rvalid_o next cycle, tests_passed_o = 1, fetch_enable_o = 0 and core_rst_no = 0 next cycle; a later write of 1 leaves tests_failed_o = 0.
REQ-042 Write 32'h5 to BASE+4 with be 4'h3 -> no effect; the same write with be 4'hF -> exit_valid_o = 1, exit_value_o = 5.
REQ-043 Write MAXCYC = 10 during RUN cycle 2 -> timeout_o = 1 after CYCLE reaches 10; reading BASE+8 afterwards returns 10.
REQ-044 EXIT write on the same edge the timeout condition becomes true -> exit_valid_o = 1, timeout_o = 0.
REQ-045 rst_ni low for one edge while in DONE -> all flags clear, CYCLE reads 0 after the HOLD sequence, outstanding rvalid_o dropped.

Source files
------------

// File: rtl/tb_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_ctrl_if
// Description : Data-bus bundle between a core-side master and the run
//               controller register window.
//               master : drives req/we/be/addr/wdata, receives gnt/rvalid/rdata
//               slave  : receives req/we/be/addr/wdata, drives gnt/rvalid/rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface tb_run_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface
`default_nettype wire

// File: rtl/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_ctrl
// Description : Test-bench run controller. Holds the core in reset for
//               RESET_WAIT_CYCLES after rst_ni releases, then runs it with
//               fetch enabled until software reports pass/fail/exit through
//               a small register window or a cycle-count timeout fires.
// Ports       :
//   clk_i          - single clock, rising-edge
//   rst_ni         - synchronous active-low reset
//   bus            - data-bus slave (req/we/be/addr/wdata -> gnt/rvalid/rdata)
//   core_rst_no    - registered active-low core reset (high only in RUN)
//   fetch_enable_o - registered core fetch enable (high only in RUN)
//   tests_passed_o, tests_failed_o, exit_valid_o, timeout_o - sticky flags
//   exit_value_o   - software exit code
// Register map (word offsets from BASE_ADDR):
//   0 STATUS (WO)  1 EXIT (WO)  2 CYCLE (RO)  3 MAXCYC (RW, 0 = no timeout)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_ctrl #(
  parameter int          RESET_WAIT_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR         = 32'h2000_0000,
  parameter logic [31:0] PASS_CODE         = 32'd123456789
) (
  input  wire logic        clk_i,
  input  wire logic        rst_ni,
  tb_run_ctrl_if.slave     bus,
  output logic             core_rst_no,
  output logic             fetch_enable_o,
  output logic             tests_passed_o,
  output logic             tests_failed_o,
  output logic             exit_valid_o,
  output logic             timeout_o,
  output logic [31:0]      exit_value_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_HOLD = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [7:0] c_HOLD_LAST = 8'(RESET_WAIT_CYCLES - 1);

  localparam logic [1:0] c_OFF_STATUS = 2'd0;
  localparam logic [1:0] c_OFF_EXIT   = 2'd1;
  localparam logic [1:0] c_OFF_CYCLE  = 2'd2;
  localparam logic [1:0] c_OFF_MAXCYC = 2'd3;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [7:0]  r_hold_cnt;
  logic [31:0] r_cycle;
  logic [31:0] r_maxcyc;
  logic [31:0] r_exit_value;
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        r_core_rst_n;
  logic        r_fetch_en;
  logic        r_passed;
  logic        r_failed;
  logic        r_exit_valid;
  logic        r_timeout;

  logic        w_gnt;
  logic        w_run_nxt;
  logic        w_in_run;
  logic        w_hit;
  logic        w_full;
  logic [1:0]  w_off;
  logic        w_wr;
  logic        w_rd;
  logic        w_status_pass;
  logic        w_status_fail;
  logic        w_exit_wr;
  logic        w_maxcyc_wr;
  logic        w_sw_done;
  logic        w_timeout_cond;
  logic        w_timeout_set;
  logic [31:0] w_rdata_nxt;
  logic        w_unused_addr;

  // --------------------------------------------------------------------------
  // Address decode and write qualification
  // --------------------------------------------------------------------------
  assign w_in_run = (r_state == c_RUN);
  assign w_off    = bus.addr_i[3:2];
  assign w_hit    = (bus.addr_i[31:4] == BASE_ADDR[31:4]);
  assign w_full   = (bus.be_i == 4'b1111);

  // Byte lane within the word carries no meaning for this window.
  assign w_unused_addr = ^bus.addr_i[1:0];

  // Only full-word writes that hit the window have any effect; everything
  // else is still granted and answered.
  assign w_wr = w_gnt & bus.we_i & w_hit & w_full;
  assign w_rd = w_gnt & ~bus.we_i;

  // Completion writes count only while running, so the flags freeze in DONE.
  assign w_status_pass = w_wr & w_in_run & (w_off == c_OFF_STATUS) &
                         (bus.wdata_i == PASS_CODE);
  assign w_status_fail = w_wr & w_in_run & (w_off == c_OFF_STATUS) &
                         (bus.wdata_i == 32'd1) & ~w_status_pass;
  assign w_exit_wr     = w_wr & w_in_run & (w_off == c_OFF_EXIT);
  assign w_maxcyc_wr   = w_wr & (w_off == c_OFF_MAXCYC);

  assign w_sw_done      = w_status_pass | w_status_fail | w_exit_wr;
  assign w_timeout_cond = w_in_run & (r_maxcyc != 32'd0) & (r_cycle >= r_maxcyc);
  // Software completion wins a tie with the timeout.
  assign w_timeout_set  = w_timeout_cond & ~w_sw_done;

  // --------------------------------------------------------------------------
  // FSM: state register (with registered core controls)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= c_HOLD;
      r_core_rst_n <= 1'b0;
      r_fetch_en   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_core_rst_n <= w_run_nxt;
      r_fetch_en   <= w_run_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_HOLD: begin
        if (r_hold_cnt == c_HOLD_LAST) begin
          w_state_nxt = c_RUN;
        end
      end
      c_RUN: begin
        if (w_sw_done || w_timeout_cond) begin
          w_state_nxt = c_DONE;
        end
      end
      c_DONE: begin
        w_state_nxt = c_DONE;
      end
      default: begin
        w_state_nxt = c_HOLD;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  // Core controls are registered from the next state so they change on the
  // same edge as the state itself.
  always_comb begin
    w_gnt     = 1'b0;
    w_run_nxt = 1'b0;
    if (r_state != c_HOLD) begin
      w_gnt = bus.req_i;
    end
    if (w_state_nxt == c_RUN) begin
      w_run_nxt = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux: zero for misses, write-only and unmapped offsets, and writes
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata_nxt = 32'd0;
    if (w_rd && w_hit) begin
      case (w_off)
        c_OFF_CYCLE:  w_rdata_nxt = r_cycle;
        c_OFF_MAXCYC: w_rdata_nxt = r_maxcyc;
        default:      w_rdata_nxt = 32'd0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Counters, registers, response path and sticky flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_hold_cnt   <= 8'd0;
      r_cycle      <= 32'd0;
      r_maxcyc     <= 32'd0;
      r_rvalid     <= 1'b0;
      r_rdata      <= 32'd0;
      r_passed     <= 1'b0;
      r_failed     <= 1'b0;
      r_exit_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_exit_value <= 32'd0;
    end else begin
      if ((r_state == c_HOLD) && (r_hold_cnt != c_HOLD_LAST)) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end

      // Counts every cycle spent in RUN, including the one that leaves it.
      if (w_in_run && (r_cycle != 32'hFFFF_FFFF)) begin
        r_cycle <= r_cycle + 32'd1;
      end

      if (w_maxcyc_wr) begin
        r_maxcyc <= bus.wdata_i;
      end

      // One-cycle response for every granted request; rdata is zero
      // whenever no response is presented.
      r_rvalid <= w_gnt;
      r_rdata  <= w_rdata_nxt;

      if (w_status_pass) begin
        r_passed <= 1'b1;
      end
      if (w_status_fail) begin
        r_failed <= 1'b1;
      end
      if (w_exit_wr) begin
        r_exit_valid <= 1'b1;
        r_exit_value <= bus.wdata_i;
      end
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = r_rvalid;
  assign bus.rdata_o  = r_rdata;

  assign core_rst_no    = r_core_rst_n;
  assign fetch_enable_o = r_fetch_en;
  assign tests_passed_o = r_passed;
  assign tests_failed_o = r_failed;
  assign exit_valid_o   = r_exit_valid;
  assign timeout_o      = r_timeout;
  assign exit_value_o   = r_exit_value;

endmodule
`default_nettype wire
